// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the sequential chunked adder.
// Saturation helper is used only when SEQ_ADDER_SAT_EN is defined.
package seq_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed limit of a width-bit two's-complement value: min when neg=1, else max.
    function automatic logic [63:0] sat_value(input int unsigned width, input logic neg);
        logic [63:0] min_v;
        min_v = 64'd1 << (width - 32'd1);
        if (neg) begin
            sat_value = min_v;
        end else begin
            sat_value = min_v - 64'd1;
        end
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple slice built from fulladder cells; also exports the
// carry into its top bit so the caller can derive signed overflow.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i]),
            .s  (s[i]),
            .co (carry_s[i+1])
        );
    end

    assign cout  = carry_s[CHUNK];
    assign c_msb = carry_s[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Optional macro SEQ_ADDER_SAT_EN clamps overflowing results to the signed limit.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  s_r;
    logic              cout_r;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;

    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK-1:0]  sum_chunk_s;
    logic              chunk_cout_s;
    logic              chunk_c_msb_s;
    logic              last_s;
    logic              ovf_next_s;
    logic [WIDTH-1:0]  s_merge_s;
    logic [WIDTH-1:0]  s_final_s;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk_s),
        .b     (b_chunk_s),
        .ci    (carry_r),
        .s     (sum_chunk_s),
        .cout  (chunk_cout_s),
        .c_msb (chunk_c_msb_s)
    );

    // Select the active operand chunk and merge the slice sum into the result.
    always_comb begin
        a_chunk_s  = a_r[int'(idx_r)*CHUNK +: CHUNK];
        b_chunk_s  = b_r[int'(idx_r)*CHUNK +: CHUNK];
        last_s     = (idx_r == IDXW'(NCHUNK - 1));
        ovf_next_s = chunk_c_msb_s ^ chunk_cout_s;
        s_merge_s  = s_r;
        s_merge_s[int'(idx_r)*CHUNK +: CHUNK] = sum_chunk_s;
`ifdef SEQ_ADDER_SAT_EN
        // Both operands share a sign on overflow, so A's sign picks the limit.
        if (last_s && ovf_next_s) begin
            s_final_s = WIDTH'(sat_value(WIDTH, a_r[WIDTH-1]));
        end else begin
            s_final_s = s_merge_s;
        end
`else
        s_final_s = s_merge_s;
`endif
    end

    // Control FSM with operand capture and chunk-by-chunk result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        s_r     <= {WIDTH{1'b0}};
                        idx_r   <= {IDXW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    s_r     <= s_final_s;
                    carry_r <= chunk_cout_s;
                    if (last_s) begin
                        idx_r   <= {IDXW{1'b0}};
                        cout_r  <= chunk_cout_s;
                        ovf_r   <= ovf_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDXW'(1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and parameter-sweep bench for seq_chunk_adder (four configurations).
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  cout_v;
    logic [3:0]  ovf_v;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [31:0] s3;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[3]), .done(done_v[3]), .s(s3), .cout(cout_v[3]), .ovf(ovf_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] obs_s(input int k);
        case (k)
            0: obs_s = {16'h0000, s0};
            1: obs_s = {16'h0000, s1};
            2: obs_s = {16'h0000, s2};
            default: obs_s = s3;
        endcase
    endfunction

    // Launch one operation on all DUTs and wait (bounded) for DUT k's done pulse.
    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic sv, output int lat, output int busy_cnt);
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy_v[k]) busy_cnt++;
            if (done_v[k]) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int lat, bc;
        run_op(0, 32'h0000_1234, 32'h0000_0FFF, 1'b0, 1'b0, lat, bc);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], s0, cout_v[0], ovf_v[0]} !== 20'h0) begin
            failures++;
            $display("FAIL reset_async: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                     busy_v[0], done_v[0], s0, cout_v[0], ovf_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        vec_t tbl[8];
        int lat, bc;
        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef SEQ_ADDER_SAT_EN
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
        tbl[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        tbl[7] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(0, {16'h0000, tbl[i].a}, {16'h0000, tbl[i].b}, tbl[i].cin, tbl[i].sub, lat, bc);
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d cycles, required 5", i, lat);
            end
            checks++;
            if (bc !== 4) begin
                failures++;
                $display("FAIL busy_cycles[%0d]: got %0d, required 4", i, bc);
            end
            checks++;
            if ({s0, cout_v[0], ovf_v[0]} !== {tbl[i].s, tbl[i].cout, tbl[i].ovf}) begin
                failures++;
                $display("FAIL result[%0d]: got s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                         i, s0, cout_v[0], ovf_v[0], tbl[i].s, tbl[i].cout, tbl[i].ovf);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        @(negedge clk);
        a = 32'h0000_1111; b = 32'h0000_2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h0000_AAAA; b = 32'h0000_5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int n = 3; n <= 40; n++) begin
            if (done_v[0]) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== 5 || s0 !== 16'h3333) begin
            failures++;
            $display("FAIL start_in_run: got lat=%0d s=%h, required lat=5 s=3333", lat, s0);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(0, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== 5 || s0 !== 16'h0300) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d s=%h, required lat=5 s=0300", lat, s0);
        end
        a = 32'h0000_4000; b = 32'h0000_1000; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_bubble: got busy=%b done=%b, required busy=1 done=0",
                     busy_v[0], done_v[0]);
        end
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done_v[0]) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== 5 || {s0, cout_v[0], ovf_v[0]} !== {16'h3000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d s=%h cout=%b ovf=%b, required lat=5 s=3000 cout=1 ovf=0",
                     lat, s0, cout_v[0], ovf_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        bit seen;
        @(negedge clk);
        a = 32'h0000_5555; b = 32'h0000_1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], s0, cout_v[0], ovf_v[0]} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                     busy_v[0], done_v[0], s0, cout_v[0], ovf_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: got done pulse, required none");
        end
        run_op(0, 32'h0000_0F0F, 32'h0000_00F1, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== 5 || s0 !== 16'h1000) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d s=%h, required lat=5 s=1000", lat, s0);
        end
    endtask

    task automatic test_sweep(input int k, input int width, input int nchunk);
        logic [63:0] mask, am, bm, bb, tot, es;
        logic        ec, eo, sa;
        logic [31:0] av, bv;
        logic        cv, sv;
        int          lat, bc;
        pulse_reset();
        mask = (64'd1 << width) - 64'd1;
        for (int i = 0; i < 200; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i % 8 == 0) bv = av ^ 32'h8000_8000;
            cv = 1'($urandom_range(0, 1));
            sv = 1'($urandom_range(0, 1));
            am  = {32'h0, av} & mask;
            bm  = {32'h0, bv} & mask;
            bb  = sv ? (~bm & mask) : bm;
            tot = am + bb + (sv ? 64'd1 : {63'd0, cv});
            es  = tot & mask;
            ec  = tot[width];
            sa  = am[width-1];
            eo  = (sa == bb[width-1]) && (es[width-1] != sa);
`ifdef SEQ_ADDER_SAT_EN
            if (eo) es = sa ? (64'd1 << (width - 1)) : ((64'd1 << (width - 1)) - 64'd1);
`endif
            run_op(k, av, bv, cv, sv, lat, bc);
            checks++;
            if (lat !== nchunk + 1 || {32'h0, obs_s(k)} !== es || cout_v[k] !== ec || ovf_v[k] !== eo) begin
                failures++;
                $display("FAIL sweep_cfg%0d[%0d]: a=%h b=%h cin=%b sub=%b got lat=%0d s=%h cout=%b ovf=%b, required lat=%0d s=%h cout=%b ovf=%b",
                         k, i, av, bv, cv, sv, lat, obs_s(k), cout_v[k], ovf_v[k],
                         nchunk + 1, es[31:0], ec, eo);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        cin = 1'b0;
        sub = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add_sub();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep(1, 16, 1);
        test_sweep(2, 16, 16);
        test_sweep(3, 32, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
